// File: rtl/pong_referee.sv
// Pong referee: hit/miss detection, scoring and serve/point/game-over sequencing per video frame.
// Latency: outputs update 3 clk after a raw vblank rise (2-flop sync + edge detect), then hold until the next frame.
// Backpressure: none; the ball mover samples change_dir/speed at its own vblank rise, one frame later.
module pong_referee #(
    parameter logic [10:0] PADDLE_L_X    = 11'd40,
    parameter logic [10:0] PADDLE_R_X    = 11'd592,
    parameter logic [10:0] PADDLE_W      = 11'd8,
    parameter logic [10:0] PADDLE_H      = 11'd64,
    parameter logic [10:0] BALL_HSIZE    = 11'd8,
    parameter logic [10:0] BALL_VSIZE    = 11'd8,
    parameter logic [3:0]  SPEED_INIT    = 4'd2,
    parameter logic [3:0]  SPEED_MAX     = 4'd9,
    parameter logic [2:0]  HITS_PER_STEP = 3'd4,
    parameter logic [3:0]  WIN_SCORE     = 4'd9,
    parameter logic [6:0]  POINT_FRAMES  = 7'd90
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblank,
    input  logic        serve,
    input  logic [10:0] ball_h_init,
    input  logic [10:0] ball_v_init,
    input  logic        ball_h_dir,
    input  logic [10:0] paddle_l_v,
    input  logic [10:0] paddle_r_v,
    output logic        change_dir,
    output logic [3:0]  speed,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        game_over
);

    // Ball direction encoding shared with the ball mover.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Geometry widened to 12 bits so the additions below cannot wrap.
    localparam logic [11:0] L_X   = {1'b0, PADDLE_L_X};
    localparam logic [11:0] R_X   = {1'b0, PADDLE_R_X};
    localparam logic [11:0] P_W   = {1'b0, PADDLE_W};
    localparam logic [11:0] P_H   = {1'b0, PADDLE_H};
    localparam logic [11:0] B_HS  = {1'b0, BALL_HSIZE};
    localparam logic [11:0] B_VS  = {1'b0, BALL_VSIZE};
    localparam logic [11:0] R_MISS_TH = R_X + P_W - B_HS;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_POINT, S_OVER} state_t;

    state_t      state;
    logic        vb_s1, vb_s2, vb_d;
    logic        tick;
    logic [2:0]  hit_cnt;
    logic [6:0]  frame_cnt;

    logic [11:0] bh, bv, pl, pr;
    logic        v_ovl_l, v_ovl_r;
    logic        hit_l, hit_r, miss_l, miss_r;

    // Synchronise vblank and keep the previous synchronised level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vb_s1 <= 1'b0;
            vb_s2 <= 1'b0;
            vb_d  <= 1'b0;
        end else begin
            vb_s1 <= vblank;
            vb_s2 <= vb_s1;
            vb_d  <= vb_s2;
        end
    end

    assign tick = vb_s2 & ~vb_d;

    assign bh = {1'b0, ball_h_init};
    assign bv = {1'b0, ball_v_init};
    assign pl = {1'b0, paddle_l_v};
    assign pr = {1'b0, paddle_r_v};

    assign v_ovl_l = (bv + B_VS >= pl) && (bv <= pl + P_H);
    assign v_ovl_r = (bv + B_VS >= pr) && (bv <= pr + P_H);

    assign hit_l  = (ball_h_dir == DIR_LEFT)  && (bh <= L_X + P_W) && (bh + B_HS >= L_X) && v_ovl_l;
    assign hit_r  = (ball_h_dir == DIR_RIGHT) && (bh <= R_X + P_W) && (bh + B_HS >= R_X) && v_ovl_r;
    assign miss_l = (ball_h_dir == DIR_LEFT)  && (bh < L_X)       && !hit_l;
    assign miss_r = (ball_h_dir == DIR_RIGHT) && (bh > R_MISS_TH) && !hit_r;

    // Game sequencer: all outputs registered, evaluated once per frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            change_dir <= 1'b0;
            speed      <= 4'd0;
            score_l    <= 4'd0;
            score_r    <= 4'd0;
            game_over  <= 1'b0;
            hit_cnt    <= 3'd0;
            frame_cnt  <= 7'd0;
        end else if (tick) begin
            // A reversal lasts exactly one frame; any other tick clears it.
            change_dir <= 1'b0;
            case (state)
                S_IDLE: begin
                    speed <= 4'd0;
                    if (serve) begin
                        state   <= S_PLAY;
                        speed   <= SPEED_INIT;
                        hit_cnt <= 3'd0;
                    end
                end
                S_PLAY: begin
                    // The frame right after a reversal ignores hits so the ball can leave the paddle.
                    if (!change_dir && (hit_l || hit_r)) begin
                        change_dir <= 1'b1;
                        if (hit_cnt == HITS_PER_STEP - 3'd1) begin
                            hit_cnt <= 3'd0;
                            if (speed < SPEED_MAX) begin
                                speed <= speed + 4'd1;
                            end
                        end else begin
                            hit_cnt <= hit_cnt + 3'd1;
                        end
                    end
                    if (miss_l) begin
                        score_r    <= score_r + 4'd1;
                        speed      <= 4'd0;
                        frame_cnt  <= 7'd0;
                        change_dir <= 1'b0;
                        if (score_r + 4'd1 == WIN_SCORE) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= S_POINT;
                        end
                    end else if (miss_r) begin
                        score_l    <= score_l + 4'd1;
                        speed      <= 4'd0;
                        frame_cnt  <= 7'd0;
                        change_dir <= 1'b0;
                        if (score_l + 4'd1 == WIN_SCORE) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= S_POINT;
                        end
                    end
                end
                S_POINT: begin
                    // Ball stays frozen for the hold period, so the miss cannot be rescored.
                    speed <= 4'd0;
                    if (frame_cnt == POINT_FRAMES - 7'd1) begin
                        state <= S_IDLE;
                    end else begin
                        frame_cnt <= frame_cnt + 7'd1;
                    end
                end
                S_OVER: begin
                    speed     <= 4'd0;
                    game_over <= 1'b1;
                    if (serve) begin
                        score_l   <= 4'd0;
                        score_r   <= 4'd0;
                        game_over <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    speed <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_referee.sv
// Testbench for pong_referee: directed game scenarios followed by random frames.
// Expected outputs come from a frame-level model of the game rules.
// Inputs are held stable across each frame tick; outputs sampled on negedge.
module tb_pong_referee;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vblank = 1'b0;
    logic        serve = 1'b0;
    logic [10:0] ball_h_init = 11'd320;
    logic [10:0] ball_v_init = 11'd240;
    logic        ball_h_dir = 1'b0;
    logic [10:0] paddle_l_v = 11'd0;
    logic [10:0] paddle_r_v = 11'd0;
    logic        change_dir;
    logic [3:0]  speed;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
    logic        game_over;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model of the game, one step per frame.
    int m_mode;   // 0 waiting for serve, 1 rally, 2 point hold, 3 game finished
    int m_spd, m_hits, m_frames, m_cd, m_sl, m_sr;

    always #5 clk = ~clk;

    pong_referee dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vblank      (vblank),
        .serve       (serve),
        .ball_h_init (ball_h_init),
        .ball_v_init (ball_v_init),
        .ball_h_dir  (ball_h_dir),
        .paddle_l_v  (paddle_l_v),
        .paddle_r_v  (paddle_r_v),
        .change_dir  (change_dir),
        .speed       (speed),
        .score_l     (score_l),
        .score_r     (score_r),
        .game_over   (game_over)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " change_dir"}, int'(change_dir), m_cd);
        chk({tag, " speed"},      int'(speed),      m_spd);
        chk({tag, " score_l"},    int'(score_l),    m_sl);
        chk({tag, " score_r"},    int'(score_r),    m_sr);
        chk({tag, " game_over"},  int'(game_over),  (m_mode == 3) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_mode = 0; m_spd = 0; m_hits = 0; m_frames = 0; m_cd = 0; m_sl = 0; m_sr = 0;
    endtask

    task automatic model_tick();
        int h, v, l, r;
        bit ovl_l, ovl_r, hl, hr, ml, mr;
        h = ball_h_init; v = ball_v_init; l = paddle_l_v; r = paddle_r_v;
        ovl_l = (v + 8 >= l) && (v <= l + 64);
        ovl_r = (v + 8 >= r) && (v <= r + 64);
        hl = (ball_h_dir == LEFT)  && (h <= 40 + 8)  && (h + 8 >= 40)  && ovl_l;
        hr = (ball_h_dir == RIGHT) && (h <= 592 + 8) && (h + 8 >= 592) && ovl_r;
        ml = (ball_h_dir == LEFT)  && (h < 40) && !hl;
        mr = (ball_h_dir == RIGHT) && (h > 592) && !hr;
        case (m_mode)
            0: begin
                m_cd = 0;
                if (serve) begin m_mode = 1; m_spd = 2; m_hits = 0; end
            end
            1: begin
                if (m_cd == 1) m_cd = 0;
                else if (hl || hr) begin
                    m_cd = 1;
                    m_hits++;
                    if (m_hits == 4) begin
                        m_hits = 0;
                        m_spd = (m_spd + 1 > 9) ? 9 : m_spd + 1;
                    end
                end
                if (ml || mr) begin
                    if (ml) m_sr++; else m_sl++;
                    m_spd = 0; m_frames = 0; m_cd = 0;
                    m_mode = (m_sl == 9 || m_sr == 9) ? 3 : 2;
                end
            end
            2: begin
                m_cd = 0;
                if (m_frames == 89) m_mode = 0;
                else m_frames++;
            end
            default: begin
                m_cd = 0;
                if (serve) begin m_sl = 0; m_sr = 0; m_mode = 0; end
            end
        endcase
    endtask

    // One video frame: raw vblank rise, tick lands 3 clk later, then vblank falls.
    task automatic frame(input string tag, input bit do_check);
        vblank = 1'b1;
        model_tick();
        repeat (5) @(negedge clk);
        if (do_check) check_all(tag);
        vblank = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic set_ball(input int h, input int v, input logic d, input int l, input int r);
        ball_h_init = 11'(h); ball_v_init = 11'(v); ball_h_dir = d;
        paddle_l_v = 11'(l); paddle_r_v = 11'(r);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Serve with latency check: nothing moves after 2 clk, speed appears after 3.
        set_ball(320, 240, LEFT, 200, 200);
        serve = 1'b1;
        vblank = 1'b1;
        model_tick();
        repeat (2) @(negedge clk);
        chk("pre_tick speed", int'(speed), 0);
        @(negedge clk);
        chk("serve speed", int'(speed), 2);
        check_all("serve");
        repeat (2) @(negedge clk);
        vblank = 1'b0;
        repeat (4) @(negedge clk);
        serve = 1'b0;

        // Left paddle hits every other frame; speed steps every fourth hit and saturates.
        set_ball(48, 100, LEFT, 80, 200);
        for (int f = 0; f < 56; f++) begin
            frame("hits", 1'b1);
            if (f == 0) chk("first hit change_dir", int'(change_dir), 1);
            if (f == 1) chk("after hit change_dir", int'(change_dir), 0);
            if (f == 6) chk("four hits speed", int'(speed), 3);
            if (f == 54) chk("28 hits speed", int'(speed), 9);
        end
        chk("hits no score", int'(score_l) + int'(score_r), 0);

        // Left miss: one point, ball held 90 frames, serve ignored meanwhile.
        set_ball(30, 100, LEFT, 300, 200);
        frame("miss_l", 1'b1);
        chk("miss_l score_r", int'(score_r), 1);
        serve = 1'b1;
        for (int f = 0; f < 89; f++) frame("point_hold", 1'b1);
        chk("point hold speed", int'(speed), 0);
        chk("point no double count", int'(score_r), 1);
        frame("point_end", 1'b1);
        frame("reserve", 1'b1);
        chk("reserve speed", int'(speed), 2);

        // Right misses until the left player wins.
        set_ball(620, 300, RIGHT, 0, 0);
        for (int k = 0; k < 9; k++) begin
            frame("miss_r", 1'b1);
            chk("miss_r score_l", int'(score_l), k + 1);
            if (k < 8) begin
                for (int f = 0; f < 91; f++) frame("point_cycle", 1'b0);
                check_all("point_cycle");
            end
        end
        chk("win game_over", int'(game_over), 1);
        serve = 1'b0;
        frame("over_hold", 1'b1);
        chk("over hold game_over", int'(game_over), 1);
        serve = 1'b1;
        frame("over_serve", 1'b1);
        chk("over clear score_l", int'(score_l), 0);
        chk("over clear game_over", int'(game_over), 0);

        // Asynchronous reset mid-rally, between ticks.
        frame("serve2", 1'b1);
        serve = 1'b0;
        set_ball(48, 100, LEFT, 80, 200);
        frame("pre_reset_hit", 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        serve = 1'b1;
        repeat (10) @(negedge clk);
        chk("no tick after reset speed", int'(speed), 0);
        frame("serve_after_reset", 1'b1);

        // Random frames around both paddles.
        for (int i = 0; i < 1500; i++) begin
            int v, h;
            logic d;
            d = 1'($urandom_range(0, 1));
            h = (d == LEFT) ? int'($urandom_range(20, 60)) : int'($urandom_range(570, 620));
            v = $urandom_range(0, 470);
            if ($urandom_range(0, 1) == 1)
                set_ball(h, v, d, (v >= 30) ? v - 30 : 0, (v >= 30) ? v - 30 : 0);
            else
                set_ball(h, v, d, $urandom_range(0, 420), $urandom_range(0, 420));
            serve = ($urandom_range(0, 3) == 0);
            frame("random", 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pong_referee.md
Name: pong_referee

Overview:
- Frame-rate game controller downstream of the ball mover. Consumes ball position/direction and both paddle positions. Detects paddle hits and misses, keeps score, and runs the serve/point/game-over sequence.
- Drives the ball mover's change_dir and speed inputs back; speed=0 freezes the ball outside play.

Parameters:
- PADDLE_L_X, 11'd40, left paddle left edge (px)
- PADDLE_R_X, 11'd592, right paddle left edge (px)
- PADDLE_W, 11'd8, paddle width
- PADDLE_H, 11'd64, paddle height
- BALL_HSIZE, 11'd8, ball width as used by ball mover
- BALL_VSIZE, 11'd8, ball height
- SPEED_INIT, 4'd2, speed at serve
- SPEED_MAX, 4'd9, speed ceiling
- HITS_PER_STEP, 3'd4, paddle hits per +1 speed
- WIN_SCORE, 4'd9, score ending the game
- POINT_FRAMES, 7'd90, frames held after a point

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vblank  in  1  vertical blank level, asynchronous to the logic; 2-flop synchronised internally
- serve  in  1  serve button, level, pre-debounced
- ball_h_init  in  11  ball left edge
- ball_v_init  in  11  ball top edge
- ball_h_dir  in  1  ball direction, `LEFT/`RIGHT from defs.v
- paddle_l_v  in  11  left paddle top edge
- paddle_r_v  in  11  right paddle top edge
- change_dir  out  1  reverse ball horizontally at next vblank rise
- speed  out  4  ball speed
- score_l  out  4  left player score
- score_r  out  4  right player score
- game_over  out  1  a player reached WIN_SCORE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - change_dir=0, speed=0, score_l=0, score_r=0, game_over=0.
  - Hit counter=0, frame counter=0, sync/edge flops=0.
  - Deassertion is taken synchronously; the first tick needs a fresh vblank 0->1.
- Frame tick:
  - One clk pulse on the synchronised vblank 0->1 edge, 3 clk after the raw edge.
  - All evaluation happens on tick only; between ticks all outputs hold.
- Overlap tests (all compares unsigned 12-bit, no wrap):
  - vertical overlap: ball_v_init+BALL_VSIZE >= pad_v and ball_v_init <= pad_v+PADDLE_H.
  - hit_l: ball_h_dir==`LEFT, ball_h_init <= PADDLE_L_X+PADDLE_W, ball_h_init+BALL_HSIZE >= PADDLE_L_X, vertical overlap with paddle_l_v.
  - hit_r: mirror with `RIGHT, PADDLE_R_X, paddle_r_v.
  - miss_l: ball_h_dir==`LEFT, ball_h_init < PADDLE_L_X, not hit_l.
  - miss_r: ball_h_dir==`RIGHT, ball_h_init > PADDLE_R_X+PADDLE_W-BALL_HSIZE, not hit_r.
- change_dir:
  - Set on a tick in PLAY when hit_l or hit_r; stays high until the next tick, so it is stable across the next vblank rise.
  - Cleared on every other tick.
  - Never two consecutive frames: a tick that sees change_dir=1 clears it and ignores hits on that tick.
- State IDLE:
  - speed=0.
  - On tick with serve=1 -> PLAY, speed=SPEED_INIT, hit counter=0.
- State PLAY, on tick:
  - Hit: hit counter +1. On reaching HITS_PER_STEP, the counter goes to 0 and speed+1, saturating at SPEED_MAX.
  - miss_l: score_r+1. miss_r: score_l+1.
  - After a miss: speed=0, frame counter=0, change_dir=0. Go to OVER if the new score == WIN_SCORE, else POINT.
  - Hit and miss for the same side are exclusive by definition.
  - Both misses together cannot occur (direction-qualified).
- State POINT:
  - speed=0; frame counter +1 per tick.
  - At POINT_FRAMES-1 -> IDLE (a serve is needed again).
  - Ball is frozen, so a miss is scored exactly once.
- State OVER:
  - game_over=1, speed=0.
  - On tick with serve=1: scores=0, game_over=0 -> IDLE.
- Scores never exceed WIN_SCORE.
- serve is ignored in PLAY and POINT.
- rst_n low mid-game returns to reset values immediately, without waiting for a tick.

Test Plan:
- Reset then serve=1 held over one vblank edge -> speed 0 then 2 after the tick; state PLAY; scores 0.
- Ball at h=48, `LEFT, v=100, paddle_l_v=80 -> change_dir=1 for exactly one frame, 0 on the following tick; no score change.
- Four consecutive hits at SPEED_INIT=2 -> speed=3 after the fourth; 28 hits total -> speed saturates at 9.
- Ball h=30, `LEFT, paddle_l_v=300 -> score_r=1, speed=0 for 90 ticks, then IDLE; ball held, no double count.
- score_l=8, miss_r -> score_l=9, game_over=1, serve ignored until OVER; serve then clears both scores to 0.
- rst_n pulsed low mid-PLAY between ticks -> all outputs 0 asynchronously; no tick is generated until the next vblank 0->1 edge.
